// File: rtl/osc_ctrl_pkg.sv
// Shared definitions for the crystal-oscillator pad sequencer: state encoding
// and default timing constants.
package osc_ctrl_pkg;

  typedef enum logic [2:0] {
    OSC_OFF     = 3'd0,
    OSC_STARTUP = 3'd1,
    OSC_CHECK   = 3'd2,
    OSC_RUN     = 3'd3,
    OSC_RETRY   = 3'd4,
    OSC_FAULT   = 3'd5
  } osc_state_e;

  localparam int OSC_STARTUP_CYC = 4096;
  localparam int OSC_WIN_CYC     = 256;
  localparam int OSC_CNT_MIN     = 16;
  localparam int OSC_CNT_MAX     = 64;
  localparam int OSC_PD_CYC      = 64;
  localparam int OSC_MAX_RETRY   = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/osc_edge_counter.sv
// Synchronises the pad XO output, detects rising edges and counts them in a
// saturating window counter that the sequencer clears between windows.
module osc_edge_counter #(
  parameter int CW = 9
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          xo_i,
  output logic [CW-1:0] cnt_o
);

  logic          xo_p0, xo_p1, xo_p2;
  logic          edge_p2;
  logic [CW-1:0] cnt_p3;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic inc);
    if (inc && (v != {CW{1'b1}})) return v + CW'(1);
    return v;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      xo_p0  <= 1'b0;
      xo_p1  <= 1'b0;
      xo_p2  <= 1'b0;
      cnt_p3 <= '0;
    end else begin
      // p0/p1: two-flop synchroniser; p2: previous sample for edge detect
      xo_p0  <= xo_i;
      xo_p1  <= xo_p0;
      xo_p2  <= xo_p1;
      // p3: window count
      cnt_p3 <= cnt_o;
    end
  end

  assign edge_p2 = xo_p1 & ~xo_p2;

  // Count-to-be includes an edge seen this cycle so a window end sees it.
  always_comb begin
    cnt_o = clr_i ? '0 : sat_inc(cnt_p3, edge_p2);
  end

endmodule

// File: rtl/osc_pad_ctrl.sv
// Start-up and supervision sequencer for the crystal-oscillator pad: powers
// the pad, waits for start-up, qualifies the XO frequency and retries/faults.
module osc_pad_ctrl import osc_ctrl_pkg::*; #(
  parameter  int STARTUP_CYC = OSC_STARTUP_CYC,
  parameter  int WIN_CYC     = OSC_WIN_CYC,
  parameter  int CNT_MIN     = OSC_CNT_MIN,
  parameter  int CNT_MAX     = OSC_CNT_MAX,
  parameter  int PD_CYC      = OSC_PD_CYC,
  parameter  int MAX_RETRY   = OSC_MAX_RETRY,
  localparam int CW          = $clog2(WIN_CYC + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          xo_i,
  output logic          pad_pd_o,
  output logic          clk_ok_o,
  output logic          busy_o,
  output logic          fault_o,
  output logic          lost_o,
  output logic [CW-1:0] last_cnt_o,
  output logic [2:0]    state_o
);

  localparam int TW = $clog2(max3(STARTUP_CYC, WIN_CYC, PD_CYC) + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);

  osc_state_e    state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [CW-1:0] last_cnt_q, last_cnt_d;
  logic          lost_q, lost_d;
  logic [CW-1:0] cnt;
  logic          cnt_clr, win_end, cnt_pass;

  // The first cycle of every window (timer 0) clears the counter, so each
  // window accumulates exactly WIN_CYC cycles of edges.
  assign cnt_clr  = !((state_q == OSC_CHECK) || (state_q == OSC_RUN)) || (tmr_q == '0);
  assign win_end  = (tmr_q == TW'(WIN_CYC));
  assign cnt_pass = (cnt >= CW'(CNT_MIN)) && (cnt <= CW'(CNT_MAX));

  osc_edge_counter #(.CW(CW)) u_edge_counter (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (cnt_clr),
    .xo_i  (xo_i),
    .cnt_o (cnt)
  );

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q + TW'(1);
    retry_d    = retry_q;
    last_cnt_d = last_cnt_q;
    lost_d     = 1'b0;
    if (!en_i) begin
      // Dropping the request wins over any window end or timer expiry.
      state_d = OSC_OFF;
      tmr_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        OSC_OFF: begin
          state_d = OSC_STARTUP;
          tmr_d   = '0;
        end
        OSC_STARTUP: begin
          if (tmr_q == TW'(STARTUP_CYC - 1)) begin
            state_d = OSC_CHECK;
            tmr_d   = '0;
          end
        end
        OSC_CHECK, OSC_RUN: begin
          if (win_end) begin
            last_cnt_d = cnt;
            tmr_d      = '0;
            if (cnt_pass) begin
              state_d = OSC_RUN;
              retry_d = '0;
            end else begin
              state_d = OSC_RETRY;
              lost_d  = (state_q == OSC_RUN);
            end
          end
        end
        OSC_RETRY: begin
          if (tmr_q == TW'(PD_CYC - 1)) begin
            tmr_d   = '0;
            retry_d = retry_q + RW'(1);
            state_d = (retry_q + RW'(1) == RW'(MAX_RETRY)) ? OSC_FAULT : OSC_STARTUP;
          end
        end
        OSC_FAULT: tmr_d = '0;
        default: begin
          state_d = OSC_OFF;
          tmr_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= OSC_OFF;
      tmr_q      <= '0;
      retry_q    <= '0;
      last_cnt_q <= '0;
      lost_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      retry_q    <= retry_d;
      last_cnt_q <= last_cnt_d;
      lost_q     <= lost_d;
    end
  end

  assign pad_pd_o   = (state_q == OSC_OFF) || (state_q == OSC_RETRY) || (state_q == OSC_FAULT);
  assign clk_ok_o   = (state_q == OSC_RUN);
  assign busy_o     = (state_q == OSC_STARTUP) || (state_q == OSC_CHECK) || (state_q == OSC_RETRY);
  assign fault_o    = (state_q == OSC_FAULT);
  assign lost_o     = lost_q;
  assign last_cnt_o = last_cnt_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_osc_pad_ctrl.sv
// Directed bench for osc_pad_ctrl with shortened timing: nominal lock, dead
// oscillator, loss in RUN, over-frequency, en_i drop priority and reset.
module tb_osc_pad_ctrl;
  import osc_ctrl_pkg::*;

  localparam int CW = $clog2(32 + 1);

  logic          clk, rst, en, xo;
  logic          pad_pd, clk_ok, busy, fault, lost;
  logic [CW-1:0] last_cnt;
  logic [2:0]    state;
  int            xo_per;
  int            ph;
  int            checks;
  int            errors;

  osc_pad_ctrl #(
    .STARTUP_CYC (16),
    .WIN_CYC     (32),
    .CNT_MIN     (6),
    .CNT_MAX     (10),
    .PD_CYC      (4),
    .MAX_RETRY   (2)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (en),
    .xo_i       (xo),
    .pad_pd_o   (pad_pd),
    .clk_ok_o   (clk_ok),
    .busy_o     (busy),
    .fault_o    (fault),
    .lost_o     (lost),
    .last_cnt_o (last_cnt),
    .state_o    (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // XO source: square wave of xo_per clk periods, or stuck low when 0.
  initial begin
    xo = 1'b0;
    ph = 0;
    forever begin
      @(posedge clk);
      #3;
      if (xo_per == 0) begin
        xo = 1'b0;
        ph = 0;
      end else begin
        ph = (ph + 1) % xo_per;
        xo = (ph < xo_per / 2);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    xo_per = 0;
    rst    = 1'b1;
    en     = 1'b1;
    tick();
    tick();
    chk("rst_state", state, OSC_OFF);
    chk("rst_pd", pad_pd, 1);
    chk("rst_clk_ok", clk_ok, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fault", fault, 0);
    chk("rst_lost", lost, 0);
    chk("rst_last_cnt", last_cnt, 0);
    rst = 1'b0;
    en  = 1'b0;
    tick();
    tick();

    // Nominal start, XO period 4
    xo_per = 4;
    en     = 1'b1;
    tick();
    chk("t1_pd_c1", pad_pd, 0);
    chk("t1_state_c1", state, OSC_STARTUP);
    chk("t1_busy_c1", busy, 1);
    repeat (15) tick();
    chk("t1_state_c16", state, OSC_STARTUP);
    tick();
    chk("t1_state_c17", state, OSC_CHECK);
    repeat (32) tick();
    chk("t1_clk_ok_c49", clk_ok, 0);
    chk("t1_state_c49", state, OSC_CHECK);
    tick();
    chk("t1_clk_ok_c50", clk_ok, 1);
    chk("t1_last_cnt", last_cnt, 8);
    chk("t1_busy_c50", busy, 0);
    chk("t1_pd_c50", pad_pd, 0);

    // Loss in RUN, then recovery
    xo_per = 0;
    for (int i = 0; i < 100 && lost !== 1'b1; i++) tick();
    chk("t3_lost", lost, 1);
    chk("t3_clk_ok", clk_ok, 0);
    chk("t3_busy", busy, 1);
    chk("t3_state", state, OSC_RETRY);
    tick();
    chk("t3_lost_pulse", lost, 0);
    xo_per = 4;
    for (int i = 0; i < 200 && clk_ok !== 1'b1; i++) tick();
    chk("t3_relock", clk_ok, 1);
    chk("t3_relock_cnt", last_cnt, 8);
    // a single further failure must not fault if the retry count was cleared
    xo_per = 0;
    for (int i = 0; i < 100 && lost !== 1'b1; i++) tick();
    chk("t3_lost2", lost, 1);
    for (int i = 0; i < 20 && state == OSC_RETRY; i++) tick();
    chk("t3_retry_cleared", state, OSC_STARTUP);
    en = 1'b0;
    tick();
    chk("t3_off", state, OSC_OFF);
    chk("t3_off_pd", pad_pd, 1);

    // Over-frequency, period 2 -> 16 edges
    xo_per = 2;
    repeat (4) tick();
    en = 1'b1;
    repeat (50) tick();
    chk("t4_state", state, OSC_RETRY);
    chk("t4_last_cnt", last_cnt, 16);
    chk("t4_clk_ok", clk_ok, 0);
    en     = 1'b0;
    xo_per = 0;
    repeat (6) tick();

    // Dead oscillator -> two retries -> FAULT
    en = 1'b1;
    repeat (50) tick();
    chk("t2_state_c50", state, OSC_RETRY);
    chk("t2_pd_c50", pad_pd, 1);
    chk("t2_last_cnt", last_cnt, 0);
    repeat (4) tick();
    chk("t2_state_c54", state, OSC_STARTUP);
    chk("t2_pd_c54", pad_pd, 0);
    repeat (52) tick();
    chk("t2_state_c106", state, OSC_RETRY);
    chk("t2_fault_c106", fault, 0);
    tick();
    chk("t2_fault_c107", fault, 1);
    chk("t2_pd_c107", pad_pd, 1);
    chk("t2_clk_ok_c107", clk_ok, 0);
    chk("t2_busy_c107", busy, 0);
    repeat (3) tick();
    chk("t2_fault_sticky", fault, 1);
    en = 1'b0;
    tick();
    chk("t5_fault_clear", fault, 0);
    chk("t5_fault_off", state, OSC_OFF);

    // en_i drop on the last cycle of a passing CHECK window
    xo_per = 4;
    repeat (5) tick();
    en = 1'b1;
    repeat (49) tick();
    chk("t5_state_c49", state, OSC_CHECK);
    en = 1'b0;
    tick();
    chk("t5_state_off", state, OSC_OFF);
    chk("t5_clk_ok", clk_ok, 0);
    chk("t5_lost", lost, 0);
    chk("t5_busy", busy, 0);
    en = 1'b1;
    tick();
    chk("t5_reenable", state, OSC_STARTUP);

    // Reset mid-CHECK and in RUN
    for (int i = 0; i < 30 && state != OSC_CHECK; i++) tick();
    repeat (5) tick();
    rst = 1'b1;
    tick();
    chk("t6_chk_state", state, OSC_OFF);
    chk("t6_chk_pd", pad_pd, 1);
    chk("t6_chk_busy", busy, 0);
    rst = 1'b0;
    for (int i = 0; i < 100 && clk_ok !== 1'b1; i++) tick();
    chk("t6_run", clk_ok, 1);
    chk("t6_run_cnt", last_cnt, 8);
    rst = 1'b1;
    tick();
    chk("t6_run_state", state, OSC_OFF);
    chk("t6_run_clk_ok", clk_ok, 0);
    chk("t6_run_last_cnt", last_cnt, 0);
    chk("t6_run_pd", pad_pd, 1);
    chk("t6_run_fault", fault, 0);
    chk("t6_run_lost", lost, 0);
    rst = 1'b0;
    en  = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
